router_out_fifo: RTL and testbench
==================================

// Module: router_out_fifo
// PURPOSE
// - Per-port output FIFO of the 1x3 router; one instance per destination port (0..2).
// - Sits directly downstream of the register stage: captures each accepted byte and tags header bytes (lfd_state).
// - Serves the destination reader, tracks packet length from the header, flags framing errors.
// - Supports a per-port soft reset driven by the synchroniser timeout.
// PARAMETERS
// - DEPTH    16  number of entries; power of two, >=4
// - DATA_W   8   payload byte width; stored word is DATA_W+1 (header tag in MSB)
// - LEN_MSB  7   header length field = data[LEN_MSB:2]; data[1:0] = destination address
// PORTS
// - clock        in   1       rising-edge clock
// - resetn       in   1       asynchronous active-low reset
// - soft_reset   in   1       synchronous flush of this port, active high
// - write_enb    in   1       write request from synchroniser
// - lfd_state    in   1       current write byte is a packet header
// - data_in      in   DATA_W  byte from register stage
// - read_enb     in   1       read request from destination
// - data_out     out  DATA_W  registered read data
// - data_valid   out  1       data_out updated by a read this cycle
// - pkt_done     out  1       one-cycle pulse: last byte (parity) of a packet read
// - frame_err    out  1       sticky: header read while previous packet incomplete
// - full         out  1       DEPTH entries held
// - empty        out  1       zero entries held
// BEHAVIOUR
// - Reset (resetn=0, async): pointers=0, byte_cnt=0, data_out=0, data_valid=0, pkt_done=0, frame_err=0; empty=1, full=0.
// - Pointers are $clog2(DEPTH)+1 bits; empty = (wr_ptr==rd_ptr); full = MSBs differ, rest equal. full/empty combinational from pointers.
// - Write accepted iff write_enb && !full: mem[wr_ptr] <= {lfd_state,data_in}; wr_ptr++. Write while full: dropped, no state change.
// - Read accepted iff read_enb && !empty: data_out <= mem[rd_ptr][DATA_W-1:0] next edge; data_valid=1 that cycle; rd_ptr++.
// - Read while empty: ignored; data_out holds last value; data_valid=0.
// - Read latency 1 cycle; write-to-readable latency 1 cycle (entry visible when empty deasserts).
// - Simultaneous accepted read and write: both happen, occupancy unchanged; at full, read accepted, write rejected (full sampled before edge).
// - Pointer wrap: modulo 2*DEPTH; index = low $clog2(DEPTH) bits.
// - byte_cnt (LEN_MSB-1 bits + 1 => 7 bits default) counts bytes remaining in current packet:
//   - header read: byte_cnt <= data[LEN_MSB:2] + 1 (payload + parity); if byte_cnt!=0 before, frame_err <= 1.
//   - non-header read with byte_cnt!=0: byte_cnt--; if byte_cnt==1, pkt_done=1 same cycle as data_valid.
//   - non-header read with byte_cnt==0: frame_err <= 1, byte_cnt stays 0.
//   - header with length 0: byte_cnt=1 (parity only).
// - soft_reset (sync): next edge pointers=0, byte_cnt=0, data_out=0, data_valid=0, pkt_done=0, frame_err=0.
//   - Dominates write_enb/read_enb in the same cycle; memory contents not cleared (unreachable).
// - resetn assertion mid-packet aborts everything; no partial state survives.
// STRUCTURE
// - Shared package router_pkg: ROUTER_DATA_W=8, ROUTER_ADDR_LSB=0, ROUTER_ADDR_MSB=1, ROUTER_LEN_LSB=2, ROUTER_LEN_MSB=7, NUM_PORTS=3.
// - Sub-module router_fifo_mem: DEPTH x (DATA_W+1) array, 1 write port, 1 registered read port, no reset on array.
// - Top holds pointers, flag logic, byte counter, error and pulse generation.
// TESTING
// - Reset then write header 8'h0D (len 3) + 3 payload + parity, read 5 -> data matches in order, pkt_done on 5th read, frame_err=0.
// - Write 16 bytes -> full=1; 17th write dropped; read 16 -> original 16 bytes, empty=1, data_out holds on extra read.
// - Occupancy 8, simultaneous read+write for 40 cycles -> occupancy stays 8, pointers wrap, order preserved.
// - Header 8'h05 (len 1) then read only 1 payload, then new header 8'h01 read -> frame_err=1, sticky until soft_reset.
// - Mid-packet soft_reset with write_enb=1 -> next cycle empty=1, data_out=0, byte_cnt=0, write discarded.
// - resetn low asynchronously between edges with full FIFO -> outputs reset immediately, empty=1 before next edge.

Source files
------------

// File: rtl/router_pkg.sv
// Shared definitions for the 1x3 router: byte layout of a header and
// the classification of a byte leaving a per-port output FIFO.
package router_pkg;

    localparam int ROUTER_DATA_W   = 8;
    localparam int ROUTER_ADDR_LSB = 0;
    localparam int ROUTER_ADDR_MSB = 1;
    localparam int ROUTER_LEN_LSB  = 2;
    localparam int ROUTER_LEN_MSB  = 7;
    localparam int NUM_PORTS       = 3;

    // What kind of read the output FIFO performs on a given cycle.
    typedef enum logic [1:0] {
        RD_NONE   = 2'd0,  // no read accepted
        RD_HEADER = 2'd1,  // header byte: reload the length counter
        RD_BODY   = 2'd2,  // payload/parity byte inside a packet
        RD_ORPHAN = 2'd3   // non-header byte with no packet open
    } rd_kind_e;

endpackage

// File: rtl/router_fifo_mem.sv
// Storage array of a router output FIFO: DEPTH words of DATA_W+1 bits
// (header tag in the MSB). One write port, one registered read port for
// the payload byte, and a combinational peek of the tag and length field
// of the head entry so the counter logic can act on the same edge.
module router_fifo_mem
    import router_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int DATA_W  = ROUTER_DATA_W,
    parameter int LEN_LSB = ROUTER_LEN_LSB,
    parameter int LEN_MSB = ROUTER_LEN_MSB,
    parameter int AW      = $clog2(DEPTH)
) (
    input  logic                       clock,
    input  logic                       resetn,
    input  logic                       clr,
    input  logic                       wr_en,
    input  logic [AW-1:0]              wr_addr,
    input  logic [DATA_W:0]            wr_data,
    input  logic                       rd_en,
    input  logic [AW-1:0]              rd_addr,
    output logic                       peek_tag,
    output logic [LEN_MSB-LEN_LSB:0]   peek_len,
    output logic [DATA_W-1:0]          rd_data
);

    logic [DATA_W:0]   mem_q [DEPTH];
    logic [DATA_W:0]   head_word;
    logic [DATA_W-1:0] rd_data_d;
    logic [DATA_W-1:0] rd_data_q;

    // Array write; contents are never reset, stale entries are unreachable.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign head_word = mem_q[rd_addr];
    assign peek_tag  = head_word[DATA_W];
    assign peek_len  = head_word[LEN_MSB:LEN_LSB];

    // Next read byte: cleared by a flush, loaded on a read, else held.
    always_comb begin
        rd_data_d = rd_data_q;
        if (clr) begin
            rd_data_d = '0;
        end else if (rd_en) begin
            rd_data_d = head_word[DATA_W-1:0];
        end
    end

    // Read data register.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/router_out_fifo.sv
// Per-port output FIFO of the 1x3 router. Buffers tagged bytes from the
// register stage, serves the destination reader, counts the bytes left in
// the packet being read, pulses pkt_done on its parity byte and raises a
// sticky frame_err on broken framing. soft_reset flushes the port.
module router_out_fifo
    import router_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int DATA_W  = ROUTER_DATA_W,
    parameter int LEN_MSB = ROUTER_LEN_MSB
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              soft_reset,
    input  logic              write_enb,
    input  logic              lfd_state,
    input  logic [DATA_W-1:0] data_in,
    input  logic              read_enb,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              pkt_done,
    output logic              frame_err,
    output logic              full,
    output logic              empty
);

    localparam int AW      = $clog2(DEPTH);
    localparam int LEN_LSB = ROUTER_LEN_LSB;
    localparam int LEN_W   = LEN_MSB - LEN_LSB + 1;
    // One extra bit so that length + parity never overflows.
    localparam int CW      = LEN_W + 1;

    logic [AW:0]    wr_ptr_d,   wr_ptr_q;
    logic [AW:0]    rd_ptr_d,   rd_ptr_q;
    logic [CW-1:0]  byte_cnt_d, byte_cnt_q;
    logic           data_valid_d, data_valid_q;
    logic           pkt_done_d,   pkt_done_q;
    logic           frame_err_d,  frame_err_q;

    logic           wr_acc;
    logic           rd_acc;
    logic           head_tag;
    logic [LEN_W-1:0] head_len;
    rd_kind_e       rd_kind;

    // Flags come straight from the pointers: the extra MSB tells a full
    // ring from an empty one when the index bits match.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // A flush wins over both requests in the same cycle.
    assign wr_acc = write_enb && !full  && !soft_reset;
    assign rd_acc = read_enb  && !empty && !soft_reset;

    router_fifo_mem #(
        .DEPTH   (DEPTH),
        .DATA_W  (DATA_W),
        .LEN_LSB (LEN_LSB),
        .LEN_MSB (LEN_MSB),
        .AW      (AW)
    ) u_mem (
        .clock    (clock),
        .resetn   (resetn),
        .clr      (soft_reset),
        .wr_en    (wr_acc),
        .wr_addr  (wr_ptr_q[AW-1:0]),
        .wr_data  ({lfd_state, data_in}),
        .rd_en    (rd_acc),
        .rd_addr  (rd_ptr_q[AW-1:0]),
        .peek_tag (head_tag),
        .peek_len (head_len),
        .rd_data  (data_out)
    );

    // Classify the byte being read this cycle from its tag and the counter.
    always_comb begin
        rd_kind = RD_NONE;
        if (rd_acc) begin
            if (head_tag) begin
                rd_kind = RD_HEADER;
            end else if (byte_cnt_q != '0) begin
                rd_kind = RD_BODY;
            end else begin
                rd_kind = RD_ORPHAN;
            end
        end
    end

    // Next-state for pointers, byte counter, valid/done pulses and error.
    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        byte_cnt_d   = byte_cnt_q;
        data_valid_d = rd_acc;
        pkt_done_d   = 1'b0;
        frame_err_d  = frame_err_q;

        if (soft_reset) begin
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            byte_cnt_d   = '0;
            data_valid_d = 1'b0;
            frame_err_d  = 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end

            case (rd_kind)
                RD_HEADER: begin
                    // Payload length plus the trailing parity byte.
                    byte_cnt_d = CW'(head_len) + CW'(1);
                    if (byte_cnt_q != '0) begin
                        frame_err_d = 1'b1;
                    end
                end
                RD_BODY: begin
                    byte_cnt_d = byte_cnt_q - CW'(1);
                    pkt_done_d = (byte_cnt_q == CW'(1));
                end
                RD_ORPHAN: begin
                    frame_err_d = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    // Control state registers.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            byte_cnt_q   <= '0;
            data_valid_q <= 1'b0;
            pkt_done_q   <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            byte_cnt_q   <= byte_cnt_d;
            data_valid_q <= data_valid_d;
            pkt_done_q   <= pkt_done_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign data_valid = data_valid_q;
    assign pkt_done   = pkt_done_q;
    assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_router_out_fifo.sv
// Bench for router_out_fifo: directed packet scenarios plus random traffic,
// all compared every cycle against a queue-based model of the port.
module tb_router_out_fifo;

    localparam int DEPTH = 16;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       soft_reset = 1'b0;
    logic       write_enb = 1'b0;
    logic       lfd_state = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       read_enb = 1'b0;
    logic [7:0] data_out;
    logic       data_valid;
    logic       pkt_done;
    logic       frame_err;
    logic       full;
    logic       empty;

    router_out_fifo #(.DEPTH(DEPTH), .DATA_W(8), .LEN_MSB(7)) dut (
        .clock      (clock),
        .resetn     (resetn),
        .soft_reset (soft_reset),
        .write_enb  (write_enb),
        .lfd_state  (lfd_state),
        .data_in    (data_in),
        .read_enb   (read_enb),
        .data_out   (data_out),
        .data_valid (data_valid),
        .pkt_done   (pkt_done),
        .frame_err  (frame_err),
        .full       (full),
        .empty      (empty)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;

    // Model: queue of {tag,byte}, plus the reader-side observable state.
    logic [8:0] mq[$];
    logic [7:0] m_dout;
    logic       m_dv;
    logic       m_pd;
    logic       m_fe;
    int         m_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_dout = 8'h00;
        m_dv   = 1'b0;
        m_pd   = 1'b0;
        m_fe   = 1'b0;
        m_cnt  = 0;
    endtask

    task automatic compare_all();
        chk("data_out",   {24'h0, data_out}, {24'h0, m_dout});
        chk("data_valid", {31'h0, data_valid}, {31'h0, m_dv});
        chk("pkt_done",   {31'h0, pkt_done}, {31'h0, m_pd});
        chk("frame_err",  {31'h0, frame_err}, {31'h0, m_fe});
        chk("full",       {31'h0, full}, (mq.size() == DEPTH) ? 32'd1 : 32'd0);
        chk("empty",      {31'h0, empty}, (mq.size() == 0) ? 32'd1 : 32'd0);
    endtask

    // One clock: decide acceptance from the pre-edge model, advance the
    // model at the edge, then compare shortly after the edge.
    task automatic step();
        logic [8:0] w;
        bit rd;
        bit wr;
        rd = read_enb && (mq.size() != 0);
        wr = write_enb && (mq.size() != DEPTH);
        @(posedge clock);
        if (soft_reset) begin
            model_reset();
        end else begin
            m_pd = 1'b0;
            m_dv = rd;
            if (rd) begin
                w = mq.pop_front();
                m_dout = w[7:0];
                if (w[8]) begin
                    if (m_cnt != 0) m_fe = 1'b1;
                    m_cnt = int'(w[7:2]) + 1;
                end else if (m_cnt != 0) begin
                    if (m_cnt == 1) m_pd = 1'b1;
                    m_cnt = m_cnt - 1;
                end else begin
                    m_fe = 1'b1;
                end
            end
            if (wr) mq.push_back({lfd_state, data_in});
        end
        #1;
        compare_all();
    endtask

    task automatic wr_byte(input logic lfd, input logic [7:0] d);
        write_enb = 1'b1; lfd_state = lfd; data_in = d; read_enb = 1'b0;
        step();
        write_enb = 1'b0; lfd_state = 1'b0;
    endtask

    task automatic rd_byte();
        read_enb = 1'b1; write_enb = 1'b0;
        step();
        read_enb = 1'b0;
    endtask

    task automatic flush();
        soft_reset = 1'b1;
        step();
        soft_reset = 1'b0;
    endtask

    initial begin
        model_reset();
        // Reset state.
        #3;
        chk("rst_empty", {31'h0, empty}, 32'd1);
        chk("rst_full", {31'h0, full}, 32'd0);
        chk("rst_dout", {24'h0, data_out}, 32'h0);
        chk("rst_dv", {31'h0, data_valid}, 32'd0);
        chk("rst_fe", {31'h0, frame_err}, 32'd0);
        @(posedge clock); #1;
        resetn = 1'b1;
        step();

        // Single well-formed packet: header 0x0D (len 3) + 3 payload + parity.
        wr_byte(1'b1, 8'h0D);
        chk("t1_not_empty", {31'h0, empty}, 32'd0);
        wr_byte(1'b0, 8'h11);
        wr_byte(1'b0, 8'h22);
        wr_byte(1'b0, 8'h33);
        wr_byte(1'b0, 8'h44);
        rd_byte();
        chk("t1_hdr", {24'h0, data_out}, 32'h0D);
        chk("t1_dv", {31'h0, data_valid}, 32'd1);
        rd_byte();
        rd_byte();
        rd_byte();
        chk("t1_done_early", {31'h0, pkt_done}, 32'd0);
        rd_byte();
        chk("t1_parity", {24'h0, data_out}, 32'h44);
        chk("t1_done", {31'h0, pkt_done}, 32'd1);
        chk("t1_fe", {31'h0, frame_err}, 32'd0);
        step();
        chk("t1_done_pulse", {31'h0, pkt_done}, 32'd0);

        // Fill to full, drop the 17th, drain, read once more while empty.
        for (int i = 0; i < 17; i++) begin
            wr_byte(1'b0, 8'(i * 7 + 3));
            if (i == 15) chk("t2_full", {31'h0, full}, 32'd1);
        end
        for (int i = 0; i < 16; i++) begin
            rd_byte();
            if (i == 0) chk("t2_first", {24'h0, data_out}, 32'h03);
        end
        chk("t2_empty", {31'h0, empty}, 32'd1);
        chk("t2_last", {24'h0, data_out}, 32'h6C);
        rd_byte();
        chk("t2_hold", {24'h0, data_out}, 32'h6C);
        chk("t2_nodv", {31'h0, data_valid}, 32'd0);
        flush();

        // Occupancy 8 with 40 cycles of simultaneous read and write.
        for (int i = 0; i < 8; i++) wr_byte(1'b0, 8'(8'h80 + i));
        for (int i = 0; i < 40; i++) begin
            write_enb = 1'b1; read_enb = 1'b1; lfd_state = 1'b0; data_in = 8'(8'h40 + i);
            step();
            if (i == 0) chk("t3_first", {24'h0, data_out}, 32'h80);
            if (i == 8) chk("t3_wrap", {24'h0, data_out}, 32'h40);
        end
        write_enb = 1'b0; read_enb = 1'b0;
        chk("t3_occ", mq.size(), 32'd8);
        flush();

        // Truncated packet followed by a new header -> sticky frame_err.
        wr_byte(1'b1, 8'h05);
        wr_byte(1'b0, 8'hAA);
        wr_byte(1'b1, 8'h01);
        rd_byte();
        rd_byte();
        chk("t4_fe_before", {31'h0, frame_err}, 32'd0);
        rd_byte();
        chk("t4_fe", {31'h0, frame_err}, 32'd1);
        step(); step(); step();
        chk("t4_sticky", {31'h0, frame_err}, 32'd1);
        flush();
        chk("t4_cleared", {31'h0, frame_err}, 32'd0);

        // Mid-packet soft reset with a concurrent write.
        wr_byte(1'b1, 8'h09);
        wr_byte(1'b0, 8'h01);
        wr_byte(1'b0, 8'h02);
        rd_byte();
        rd_byte();
        soft_reset = 1'b1; write_enb = 1'b1; data_in = 8'h77;
        step();
        soft_reset = 1'b0; write_enb = 1'b0;
        chk("t5_empty", {31'h0, empty}, 32'd1);
        chk("t5_dout", {24'h0, data_out}, 32'h0);
        wr_byte(1'b0, 8'h55);
        rd_byte();
        chk("t5_cnt_zero", {31'h0, frame_err}, 32'd1);
        flush();

        // Asynchronous reset between edges with a full FIFO.
        for (int i = 0; i < 16; i++) wr_byte(1'b0, 8'(8'hC0 + i));
        rd_byte();
        wr_byte(1'b0, 8'hEE);
        #2;
        resetn = 1'b0;
        #1;
        chk("t6_empty", {31'h0, empty}, 32'd1);
        chk("t6_full", {31'h0, full}, 32'd0);
        chk("t6_dout", {24'h0, data_out}, 32'h0);
        model_reset();
        @(posedge clock); #1;
        compare_all();
        resetn = 1'b1;
        step();

        // Random traffic, mostly well-formed packets mixed with noise.
        for (int i = 0; i < 1500; i++) begin
            soft_reset = ($urandom_range(0, 199) == 0);
            write_enb  = ($urandom_range(0, 9) < 6);
            read_enb   = ($urandom_range(0, 9) < 5);
            lfd_state  = ($urandom_range(0, 4) == 0);
            data_in    = lfd_state ? 8'($urandom_range(0, 15)) : 8'($urandom);
            step();
        end
        soft_reset = 1'b0; write_enb = 1'b0; read_enb = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
